image_process_top: RTL and testbench

- Streaming 8-bit grayscale pixel-processing block between the video timing/pixel source and the result sink (display or dump).
- Binarizes each pixel against a fixed threshold, then cleans the mask with a 3x3 morphological erosion.
- Output is 8'hFF (foreground) or 8'h00 (background), with sync/enable delayed to stay aligned.
- Fixed latency of 3 clocks; no back-pressure.

---
 rtl/image_process_top.sv | 142 ++++++++++++++
 tb/tb_image_process_top.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/image_process_top.sv
// Streaming 8-bit grayscale binarizer with optional 3x3 erosion cleanup; fixed 3-clock latency.
// Build with IMAGE_PROCESS_ERODE_EN defined to include the line buffers and erosion window.
module image_process_top #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int THRESH = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_hsync,
  input  logic        pre_frame_de,
  input  logic [7:0]  pre_rgb,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  output logic        post_frame_vsync,
  output logic        post_frame_hsync,
  output logic        post_frame_de,
  output logic [7:0]  post_rgb
);
  localparam int STAGES = 3;

  logic [STAGES-1:0] vld_pipe, vs_pipe, hs_pipe;
  logic              bin_now, bin1;
  logic [7:0]        rgb_q;
  logic              unused_ok;

  assign unused_ok = ^{xpos, ypos};
  assign bin_now   = pre_rgb >= 8'(THRESH);

  // vld_pipe[0] doubles as "previous de" for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      vs_pipe  <= '0;
      hs_pipe  <= '0;
      bin1     <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], pre_frame_de};
      vs_pipe  <= {vs_pipe[STAGES-2:0], pre_frame_vsync};
      hs_pipe  <= {hs_pipe[STAGES-2:0], pre_frame_hsync};
      if (pre_frame_de) bin1 <= bin_now;
    end
  end

`ifdef IMAGE_PROCESS_ERODE_EN
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_cnt, col1, col2;
  logic [RW-1:0] row_cnt, row1, row2;
  logic          lb_a [IMG_W];
  logic          lb_b [IMG_W];
  logic          top1, mid1;
  logic [2:0]    win_t, win_m, win_b;
  logic          full_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (pre_frame_de) begin
        if (col_cnt != CW'(IMG_W - 1)) col_cnt <= col_cnt + 1'b1;
      end else if (vld_pipe[0]) begin
        col_cnt <= '0;
      end
      if (pre_frame_vsync)
        row_cnt <= '0;
      else if (!pre_frame_de && vld_pipe[0] && row_cnt != RW'(IMG_H - 1))
        row_cnt <= row_cnt + 1'b1;
    end
  end

  // A holds the previous row, B the one before; B takes A's old bit as A is overwritten
  always_ff @(posedge clk) begin
    if (pre_frame_de) begin
      lb_a[col_cnt] <= bin_now;
      lb_b[col_cnt] <= lb_a[col_cnt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top1 <= 1'b0;
      mid1 <= 1'b0;
      col1 <= '0;
      row1 <= '0;
    end else if (pre_frame_de) begin
      top1 <= lb_b[col_cnt];
      mid1 <= lb_a[col_cnt];
      col1 <= col_cnt;
      row1 <= row_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_t <= '0;
      win_m <= '0;
      win_b <= '0;
      col2  <= '0;
      row2  <= '0;
    end else if (vld_pipe[0]) begin
      win_t <= {win_t[1:0], top1};
      win_m <= {win_m[1:0], mid1};
      win_b <= {win_b[1:0], bin1};
      col2  <= col1;
      row2  <= row1;
    end
  end

  // Window spans rows r-2..r, cols c-2..c, so the result lands one pixel down-right
  assign full_win = (&{win_t, win_m, win_b}) && (row2 >= RW'(2)) && (col2 >= CW'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= 8'h00;
    else        rgb_q <= (vld_pipe[1] && full_win) ? 8'hFF : 8'h00;
  end
`else
  logic bin2;
  logic unused_cfg;

  assign unused_cfg = ^{32'(IMG_W), 32'(IMG_H)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin2  <= 1'b0;
      rgb_q <= 8'h00;
    end else begin
      bin2  <= bin1;
      rgb_q <= (vld_pipe[1] && bin2) ? 8'hFF : 8'h00;
    end
  end
`endif

  assign post_frame_vsync = vs_pipe[STAGES-1];
  assign post_frame_hsync = hs_pipe[STAGES-1];
  assign post_frame_de    = vld_pipe[STAGES-1];
  assign post_rgb         = rgb_q;

endmodule

// File: tb/tb_image_process_top.sv
// Directed bench for image_process_top on a small 8x6 frame; expectations follow the build macro.
module tb_image_process_top;
  localparam int W = 8, H = 6, HT = 12, VS_L = 2, LINES = H + 4, TH = 150;
`ifdef IMAGE_PROCESS_ERODE_EN
  localparam bit ERODE = 1'b1;
`else
  localparam bit ERODE = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic [7:0]  pix = 8'h00;
  logic [10:0] xpos = '0, ypos = '0;
  logic        post_vs, post_hs, post_de;
  logic [7:0]  post_rgb;

  logic [7:0]  img [H][W];
  logic [10:0] hist [3];
  int checks = 0, failures = 0, ff_cnt = 0;

  typedef struct {
    int bg; int fg; int r0; int c0; int sz; int n_erode; int n_plain;
  } case_t;
  case_t cases [6];

  always #5 clk = ~clk;

  image_process_top #(.IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
    .clk(clk), .rst_n(rst_n),
    .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de), .pre_rgb(pix),
    .xpos(xpos), .ypos(ypos),
    .post_frame_vsync(post_vs), .post_frame_hsync(post_hs), .post_frame_de(post_de),
    .post_rgb(post_rgb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input int r, input int c);
    if (!ERODE) return (img[r][c] >= 8'(TH)) ? 8'hFF : 8'h00;
    if (r < 2 || c < 2) return 8'h00;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (img[r-i][c-j] < 8'(TH)) return 8'h00;
    return 8'hFF;
  endfunction

  task automatic load_img(input case_t k);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (r >= k.r0 && r < k.r0 + k.sz && c >= k.c0 && c < k.c0 + k.sz) ? 8'(k.fg) : 8'(k.bg);
  endtask

  // Called at negedge: drive, clock, then compare against the record from two edges back
  task automatic cyc(input logic v, input logic h, input logic d, input logic [7:0] p,
                     input logic [7:0] e, input bit chk);
    vs = v; hs = h; de = d; pix = p;
    xpos = 11'($urandom); ypos = 11'($urandom);
    @(posedge clk);
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = {v, h, d, e};
    @(negedge clk);
    if (chk) begin
      check("pipe_out", {21'd0, post_vs, post_hs, post_de, post_rgb}, {21'd0, hist[2]});
      if (post_rgb == 8'hFF) ff_cnt++;
    end
  endtask

  task automatic run_frame(input bit chk_in, input int rst_row);
    bit chk;
    bit v, h, d;
    int r;
    logic [7:0] p, e;
    chk = chk_in;
    for (int l = 0; l < LINES; l++) begin
      for (int x = 0; x < HT; x++) begin
        v = (l < VS_L);
        h = (x >= W + 1 && x < W + 3);
        d = (l >= 3 && l < 3 + H && x < W);
        r = l - 3;
        p = 8'($urandom);
        e = 8'h00;
        if (d) begin
          p = img[r][x];
          e = model(r, x);
        end
        if (d && r == rst_row && x == W / 2) begin
          #2 rst_n = 1'b0;
          #1 check("rst_async", {21'd0, post_vs, post_hs, post_de, post_rgb}, 32'd0);
          @(posedge clk);
          @(negedge clk);
          check("rst_hold", {21'd0, post_vs, post_hs, post_de, post_rgb}, 32'd0);
          rst_n = 1'b1;
          for (int i = 0; i < 3; i++) hist[i] = '0;
          chk = 1'b0;
        end
        cyc(v, h, d, p, e, chk);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '0;
    cases[0] = '{200, 200, 0, 0, 0, 24, 48};
    cases[1] = '{149, 149, 0, 0, 0, 0, 0};
    cases[2] = '{150, 150, 0, 0, 0, 24, 48};
    cases[3] = '{0, 255, 3, 4, 1, 0, 1};
    cases[4] = '{0, 255, 1, 2, 5, 9, 25};
    cases[5] = '{150, 149, 3, 3, 1, 15, 47};

    // Reset held with toggling inputs
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      vs = 1'($urandom); hs = 1'($urandom); de = 1'($urandom); pix = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("reset_out", {21'd0, post_vs, post_hs, post_de, post_rgb}, 32'd0);
    end
    rst_n = 1'b1;

    // Short de runs (<=2 pixels) keep col<2, so erosion yields 0 while plain mode gives FF
    for (int i = 0; i < 15; i++)
      cyc(1'b0, (i % 5 == 0), (i % 3 != 2), 8'd200,
          ((i % 3 != 2) && !ERODE) ? 8'hFF : 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    for (int k = 0; k < 6; k++) begin
      load_img(cases[k]);
      ff_cnt = 0;
      run_frame(1'b1, -1);
      check($sformatf("ff_count_case%0d", k), 32'(ff_cnt),
            32'(ERODE ? cases[k].n_erode : cases[k].n_plain));
    end

    // Mid-frame reset, then a clean uniform frame
    load_img(cases[0]);
    run_frame(1'b1, 3);
    ff_cnt = 0;
    run_frame(1'b1, -1);
    check("ff_count_after_reset", 32'(ff_cnt), 32'(ERODE ? 24 : 48));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
